// File: rtl/mips_avalon_pkg.sv
// mips_avalon_pkg: shared arbiter state type, master indices and default timeout
package mips_avalon_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;
    localparam int M_INSTR = 0;
    localparam int M_DATA = 1;
    localparam int TIMEOUT_DEFAULT = 1024;
endpackage

// File: rtl/mips_avalon_rr_pick.sv
// mips_avalon_rr_pick: 2-way round-robin / fixed-priority picker, pick = winning master index
module mips_avalon_rr_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       prio_data,
    output logic       pick
);
    always_comb pick = (req == 2'b11) ? (prio_data | ~last_grant) : req[1];
endmodule

// File: rtl/mips_avalon_arbiter.sv
// mips_avalon_arbiter: arbitrates instruction (m0) and data (m1) Avalon masters onto one slave
module mips_avalon_arbiter
    import mips_avalon_pkg::*;
#(
    parameter int TIMEOUT   = TIMEOUT_DEFAULT,
    parameter bit PRIO_DATA = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    output logic [1:0]  grant,
    output logic        err_timeout,
    output logic        err_protocol
);
    localparam int CW = $clog2(TIMEOUT + 1);
    arb_state_t state, state_nx;
    logic          last_grant;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    req;
    logic          pick, gnt, own, own_req, own_rw;
    mips_avalon_rr_pick u_pick (
        .req        (req),
        .last_grant (last_grant),
        .prio_data  (PRIO_DATA),
        .pick       (pick)
    );
    always_comb begin
        req            = {m1_read | m1_write, m0_read | m0_write};
        gnt            = state != IDLE;
        own            = state == GNT1;
        own_req        = req[own];
        own_rw         = own ? (m1_read & m1_write) : (m0_read & m0_write);
        grant          = {state == GNT1, state == GNT0};
        s_read         = gnt & (own ? m1_read : m0_read);
        s_write        = gnt & (own ? m1_write : m0_write);
        s_address      = !gnt ? '0 : own ? m1_address : m0_address;
        s_writedata    = !gnt ? '0 : own ? m1_writedata : m0_writedata;
        s_byteenable   = !gnt ? '0 : own ? m1_byteenable : m0_byteenable;
        m0_waitrequest = (state == GNT0) ? s_waitrequest : req[0];
        m1_waitrequest = (state == GNT1) ? s_waitrequest : req[1];
        m0_readdata    = s_readdata;
        m1_readdata    = s_readdata;
    end
    always_comb begin
        state_nx = state;
        if (!gnt) begin
            if (|req) state_nx = pick ? GNT1 : GNT0;
        end else if (!own_req || !s_waitrequest) begin
            state_nx = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'(M_DATA);
            wait_cnt     <= '0;
            err_timeout  <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            state <= state_nx;
            if (!gnt)
                wait_cnt <= '0;
            else if (s_waitrequest && wait_cnt != CW'(TIMEOUT))
                wait_cnt <= wait_cnt + 1'b1;
            // flag rises on the same edge the counter reaches TIMEOUT
            if (gnt && s_waitrequest && wait_cnt == CW'(TIMEOUT - 1))
                err_timeout <= 1'b1;
            if (gnt && (own_rw || (!own_req && s_waitrequest)))
                err_protocol <= 1'b1;
            if (gnt && own_req && !s_waitrequest)
                last_grant <= own;
        end
    end
endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// tb_mips_avalon_arbiter: random + directed check of round-robin and priority arbiters against a reference model
module tb_mips_avalon_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr [2];
    logic [31:0] wd [2];
    logic [3:0]  be [2];
    logic        rd [2];
    logic        wr [2];
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        m0_waitrequest [2], m1_waitrequest [2];
    logic [31:0] m0_readdata [2], m1_readdata [2];
    logic [31:0] s_address [2], s_writedata [2];
    logic [3:0]  s_byteenable [2];
    logic        s_read [2], s_write [2];
    logic [1:0]  grant [2];
    logic        err_timeout [2], err_protocol [2];
    int vectors = 0;
    int miscompares = 0;
    int own [2], last [2], cnt [2];
    bit et [2], ep [2];
    bit acc [2];
    int wprob = 30;
    always #5 clk = ~clk;
    for (genvar p = 0; p < 2; p++) begin : g
        mips_avalon_arbiter #(.TIMEOUT(8), .PRIO_DATA(p == 1)) dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .m0_address     (addr[0]),
            .m0_read        (rd[0]),
            .m0_write       (wr[0]),
            .m0_writedata   (wd[0]),
            .m0_byteenable  (be[0]),
            .m0_waitrequest (m0_waitrequest[p]),
            .m0_readdata    (m0_readdata[p]),
            .m1_address     (addr[1]),
            .m1_read        (rd[1]),
            .m1_write       (wr[1]),
            .m1_writedata   (wd[1]),
            .m1_byteenable  (be[1]),
            .m1_waitrequest (m1_waitrequest[p]),
            .m1_readdata    (m1_readdata[p]),
            .s_address      (s_address[p]),
            .s_read         (s_read[p]),
            .s_write        (s_write[p]),
            .s_writedata    (s_writedata[p]),
            .s_byteenable   (s_byteenable[p]),
            .s_waitrequest  (s_waitrequest),
            .s_readdata     (s_readdata),
            .grant          (grant[p]),
            .err_timeout    (err_timeout[p]),
            .err_protocol   (err_protocol[p])
        );
    end
    task automatic chk(input string tag, input int p, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s[dut%0d] @%0t: got %h expected %h", tag, p, $time, got, exp);
        end
    endtask
    function automatic bit exp_wait(int p, int i);
        return (own[p] == i + 1) ? s_waitrequest : (rd[i] | wr[i]);
    endfunction
    // compare all outputs, advance the model across one posedge, return at the next negedge
    task automatic step();
        int n_own [2], n_last [2], n_cnt [2];
        bit n_et [2], n_ep [2];
        #1;
        for (int p = 0; p < 2; p++) begin
            int x;
            x = own[p] - 1;
            chk("grant", p, 32'(grant[p]), own[p] == 0 ? 0 : (own[p] == 1 ? 1 : 2));
            chk("s_read", p, 32'(s_read[p]), own[p] == 0 ? 0 : 32'(rd[x]));
            chk("s_write", p, 32'(s_write[p]), own[p] == 0 ? 0 : 32'(wr[x]));
            if (own[p] != 0) begin
                chk("s_address", p, s_address[p], addr[x]);
                chk("s_writedata", p, s_writedata[p], wd[x]);
                chk("s_byteenable", p, 32'(s_byteenable[p]), 32'(be[x]));
            end
            chk("m0_wait", p, 32'(m0_waitrequest[p]), 32'(exp_wait(p, 0)));
            chk("m1_wait", p, 32'(m1_waitrequest[p]), 32'(exp_wait(p, 1)));
            chk("m0_rdata", p, m0_readdata[p], s_readdata);
            chk("m1_rdata", p, m1_readdata[p], s_readdata);
            chk("err_timeout", p, 32'(err_timeout[p]), 32'(et[p]));
            chk("err_protocol", p, 32'(err_protocol[p]), 32'(ep[p]));
            n_own[p] = own[p]; n_last[p] = last[p]; n_cnt[p] = cnt[p];
            n_et[p] = et[p]; n_ep[p] = ep[p];
            if (!rst_n) begin
                n_own[p] = 0; n_last[p] = 1; n_cnt[p] = 0; n_et[p] = 0; n_ep[p] = 0;
            end else if (own[p] == 0) begin
                bit r0, r1;
                r0 = rd[0] | wr[0];
                r1 = rd[1] | wr[1];
                n_cnt[p] = 0;
                if (r0 && r1) n_own[p] = (p == 1 || last[p] == 0) ? 2 : 1;
                else if (r0) n_own[p] = 1;
                else if (r1) n_own[p] = 2;
            end else begin
                if (rd[x] && wr[x]) n_ep[p] = 1;
                if (s_waitrequest) begin
                    n_cnt[p] = cnt[p] < 8 ? cnt[p] + 1 : 8;
                    if (n_cnt[p] == 8) n_et[p] = 1;
                end
                if (!(rd[x] | wr[x])) begin
                    if (s_waitrequest) n_ep[p] = 1;
                    n_own[p] = 0;
                end else if (!s_waitrequest) begin
                    n_own[p] = 0;
                    n_last[p] = x;
                end
            end
        end
        for (int i = 0; i < 2; i++) acc[i] = !rst_n || ((rd[i] | wr[i]) && !exp_wait(0, i));
        @(posedge clk);
        own = n_own; last = n_last; cnt = n_cnt; et = n_et; ep = n_ep;
        @(negedge clk);
    endtask
    task automatic agents();
        for (int i = 0; i < 2; i++) begin
            if ((rd[i] | wr[i]) && !acc[i]) begin
                if ($urandom_range(0, 99) < 3) begin rd[i] = 0; wr[i] = 0; end
            end else if ($urandom_range(0, 1) == 1) begin
                int k;
                k = $urandom_range(0, 99);
                rd[i] = k < 50;
                wr[i] = k < 3 || k >= 50;
                addr[i] = (i == 0 && k % 4 == 0) ? 32'hBFC0_0000 : ($urandom & 32'hFFFF_FFFC);
                wd[i] = $urandom;
                be[i] = 4'($urandom_range(1, 15));
            end else begin
                rd[i] = 0; wr[i] = 0;
            end
        end
        s_waitrequest = $urandom_range(0, 99) < wprob;
        s_readdata = $urandom;
    endtask
    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            rd[i] = 0; wr[i] = 0; addr[i] = 0; wd[i] = 0; be[i] = 0;
        end
        s_waitrequest = 0;
        s_readdata = 32'h1234_5678;
    endtask
    task automatic do_reset();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask
    initial begin
        rst_n = 0;
        idle_inputs();
        own = '{0, 0}; last = '{1, 1}; cnt = '{0, 0}; et = '{0, 0}; ep = '{0, 0}; acc = '{0, 0};
        @(negedge clk);
        do_reset();
        for (int p = 0; p < 2; p++) chk("reset_grant", p, 32'(grant[p]), 0);
        // contention: m0 fetch vs m1 write, zero-wait slave
        rd[0] = 1; addr[0] = 32'hBFC0_0000; be[0] = 4'hF;
        wr[1] = 1; addr[1] = 32'h0000_0010; wd[1] = 32'hDEAD_BEEF; be[1] = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("rr_seq", 0, 32'(grant[0]), (c % 2 == 1) ? 0 : ((c % 4 == 0) ? 1 : 2));
            chk("prio_seq", 1, 32'(grant[1]), (c % 2 == 1) ? 0 : 2);
        end
        // stuck slave: m1 only, timeout after 8 wait cycles, grant held
        do_reset();
        rd[0] = 0;
        s_waitrequest = 1;
        for (int c = 0; c < 12; c++) begin
            step();
            chk("timeout_edge", 0, 32'(err_timeout[0]), c >= 8);
            chk("timeout_hold", 0, 32'(grant[0]), 2);
        end
        rst_n = 0;
        step();
        rst_n = 1;
        chk("rst_mid_grant", 0, 32'(grant[0]), 0);
        chk("rst_mid_write", 0, 32'(s_write[0]), 0);
        // m0 read abandoned while slave is waiting
        do_reset();
        wr[1] = 0;
        rd[0] = 1;
        step();
        step();
        rd[0] = 0;
        step();
        chk("proto_err", 0, 32'(err_protocol[0]), 1);
        chk("proto_idle", 0, 32'(grant[0]), 0);
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            if (c % 100 == 0) wprob = (c / 100) % 4 == 3 ? 90 : ((c / 100) % 4) * 25;
            agents();
            rst_n = (c % 300 != 299);
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
